// File: rtl/jt12_mix_pkg.sv
// Shared constants, slot kind and saturation helper for the jt12 TDM mixer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jt12_mix_pkg;

  localparam logic [7:0] GAIN_UNITY = 8'h10;  // 1.0 in 4.4 fixed point
  localparam int         GAIN_FRAC  = 4;
  localparam int         FILT_FRAC  = 8;
  localparam int         KMAX       = 8;

  typedef enum logic {
    SLOT_ACC = 1'b0,
    SLOT_OUT = 1'b1
  } slot_kind_e;

  // Clamp a sign-extended value to the range of an ow-bit signed number.
  // The caller sign-extends its source into the 64-bit container, so any
  // input width up to 64 is supported.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int                 ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r  = v;
    if (v > hi) r = hi;
    if (v < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/jt12_mix_lpf.sv
// One-pole low-pass update slice: f_new = f + ((x - f) >>> k), k clamped to KMAX, k=0 bypasses.
// Latency: combinational.
// Backpressure: none.
// Ports: f (current state), x (target, same scale as f), k (shift), f_new (next state).
module jt12_mix_lpf
  import jt12_mix_pkg::*;
#(
  parameter int FW = 24
) (
  input  logic signed [FW-1:0] f,
  input  logic signed [FW-1:0] x,
  input  logic        [3:0]    k,
  output logic signed [FW-1:0] f_new
);

  logic        [3:0] kc;
  logic signed [FW:0] diff;

  always_comb begin
    kc   = (k > 4'(KMAX)) ? 4'(KMAX) : k;
    // One guard bit: x - f can span twice the state range.
    diff = (FW+1)'(x) - (FW+1)'(f);
    if (kc == 4'd0) begin
      f_new = x;
    end else begin
      // f + (diff >>> kc) always lies between f and x, so it fits in FW bits.
      f_new = FW'((FW+1)'(f) + (diff >>> kc));
    end
  end

endmodule

// File: rtl/jt12_tdm_mixer.sv
// Round-robin CH-channel mixer: per-channel hold, one-pole smoothing, gain, sum, saturate.
// Latency: one frame of CH+1 clocks per output; din_ce to snd at most 2*(CH+1)+1 clocks (k=0).
// Backpressure: none; snd_ce is a free-running one-clock strobe every CH+1 clocks.
// Ports: din/din_ce (packed samples + per-channel strobes), gain (4.4 unsigned), kshift
//        (smoothing shift), clip_clr; outputs snd (signed mix), snd_ce, clip (sticky).
module jt12_tdm_mixer
  import jt12_mix_pkg::*;
#(
  parameter int CH = 2,
  parameter int W  = 16,
  parameter int GW = 8,
  parameter int OW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   din,
  input  logic [CH-1:0]     din_ce,
  input  logic [CH*GW-1:0]  gain,
  input  logic [CH*4-1:0]   kshift,
  input  logic              clip_clr,
  output logic [OW-1:0]     snd,
  output logic              snd_ce,
  output logic              clip
);

  localparam int FW = W + FILT_FRAC;
  localparam int SW = $clog2(CH + 1);
  localparam int AW = W + GW + $clog2(CH) + 2;
  localparam int PW = W + GW + 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(CH);

  logic signed [W-1:0]  din_a  [CH];
  logic        [GW-1:0] gain_a [CH];
  logic        [3:0]    k_a    [CH];

  logic signed [W-1:0]  hold_q [CH];
  logic signed [W-1:0]  hold_d [CH];
  logic signed [FW-1:0] f_q    [CH];
  logic signed [FW-1:0] f_d    [CH];
  logic [SW-1:0]        slot_q, slot_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [OW-1:0]        snd_q, snd_d;
  logic                 snd_ce_q, snd_ce_d;
  logic                 clip_q, clip_d;

  slot_kind_e           kind;
  logic signed [W-1:0]  sel_hold;
  logic signed [FW-1:0] sel_f;
  logic        [GW-1:0] sel_gain;
  logic        [3:0]    sel_k;
  logic signed [FW-1:0] lpf_x;
  logic signed [FW-1:0] f_new;
  logic signed [W-1:0]  f_int;
  logic signed [GW:0]   g_s;
  logic signed [PW-1:0] prod;
  logic signed [63:0]   acc_sh;
  logic signed [63:0]   acc_sat;

  for (genvar i = 0; i < CH; i++) begin : g_unpack
    assign din_a[i]  = din[i*W +: W];
    assign gain_a[i] = gain[i*GW +: GW];
    assign k_a[i]    = kshift[i*4 +: 4];
  end

  assign kind = (slot_q == SLOT_LAST) ? SLOT_OUT : SLOT_ACC;

  // Operand mux for the single shared filter/MAC datapath. In the OUT slot no
  // channel matches and the operands sit at zero; their result is unused.
  always_comb begin
    sel_hold = '0;
    sel_f    = '0;
    sel_gain = '0;
    sel_k    = '0;
    for (int i = 0; i < CH; i++) begin
      if (slot_q == SW'(i)) begin
        sel_hold = hold_q[i];
        sel_f    = f_q[i];
        sel_gain = gain_a[i];
        sel_k    = k_a[i];
      end
    end
  end

  assign lpf_x = {sel_hold, {FILT_FRAC{1'b0}}};

  jt12_mix_lpf #(.FW(FW)) u_lpf (
    .f     (sel_f),
    .x     (lpf_x),
    .k     (sel_k),
    .f_new (f_new)
  );

  // Integer part of the freshly updated state (floor) times unsigned gain.
  assign f_int = f_new[FW-1:FILT_FRAC];
  assign g_s   = {1'b0, sel_gain};
  assign prod  = PW'(f_int) * PW'(g_s);

  always_comb begin
    slot_d   = (kind == SLOT_OUT) ? '0 : slot_q + SW'(1);
    acc_d    = acc_q;
    snd_d    = snd_q;
    snd_ce_d = 1'b0;
    clip_d   = clip_q;
    acc_sh   = 64'(acc_q) >>> GAIN_FRAC;
    acc_sat  = sat_clamp(acc_sh, OW);

    // Holds update independently of the schedule; ACC slots read hold_q, so a
    // strobe landing on its own slot is picked up next frame.
    for (int i = 0; i < CH; i++) begin
      hold_d[i] = din_ce[i] ? din_a[i] : hold_q[i];
      f_d[i]    = f_q[i];
    end

    if (clip_clr) clip_d = 1'b0;

    if (kind == SLOT_ACC) begin
      acc_d = acc_q + AW'(prod);
      for (int i = 0; i < CH; i++) begin
        if (slot_q == SW'(i)) f_d[i] = f_new;
      end
    end else begin
      snd_d    = acc_sat[OW-1:0];
      snd_ce_d = 1'b1;
      acc_d    = '0;
      // A saturating output overrides a simultaneous clear.
      if (acc_sat != acc_sh) clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      acc_q    <= '0;
      snd_q    <= '0;
      snd_ce_q <= 1'b0;
      clip_q   <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        hold_q[i] <= '0;
        f_q[i]    <= '0;
      end
    end else begin
      slot_q   <= slot_d;
      acc_q    <= acc_d;
      snd_q    <= snd_d;
      snd_ce_q <= snd_ce_d;
      clip_q   <= clip_d;
      for (int i = 0; i < CH; i++) begin
        hold_q[i] <= hold_d[i];
        f_q[i]    <= f_d[i];
      end
    end
  end

  assign snd    = snd_q;
  assign snd_ce = snd_ce_q;
  assign clip   = clip_q;

endmodule

// File: tb/tb_jt12_tdm_mixer.sv
// Bench for jt12_tdm_mixer: directed vector table on a CH=2 instance, hand-written
// clip/reset sequences, and randomized traffic on a CH=5 instance against a model.
module tb_jt12_tdm_mixer;

  localparam int CHB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: CH=2 ----------------
  logic        rst_a;
  logic [31:0] din_a;
  logic [1:0]  din_ce_a;
  logic [15:0] gain_a;
  logic [7:0]  kshift_a;
  logic        clip_clr_a;
  logic [15:0] snd_a;
  logic        snd_ce_a;
  logic        clip_a;

  jt12_tdm_mixer #(.CH(2), .W(16), .GW(8), .OW(16)) dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .din      (din_a),
    .din_ce   (din_ce_a),
    .gain     (gain_a),
    .kshift   (kshift_a),
    .clip_clr (clip_clr_a),
    .snd      (snd_a),
    .snd_ce   (snd_ce_a),
    .clip     (clip_a)
  );

  // ---------------- instance B: CH=5 ----------------
  logic               rst_b;
  logic [CHB*16-1:0]  din_b;
  logic [CHB-1:0]     din_ce_b;
  logic [CHB*8-1:0]   gain_b;
  logic [CHB*4-1:0]   kshift_b;
  logic               clip_clr_b;
  logic [15:0]        snd_b;
  logic               snd_ce_b;
  logic               clip_b;

  jt12_tdm_mixer #(.CH(CHB), .W(16), .GW(8), .OW(16)) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .din      (din_b),
    .din_ce   (din_ce_b),
    .gain     (gain_b),
    .kshift   (kshift_b),
    .clip_clr (clip_clr_b),
    .snd      (snd_b),
    .snd_ce   (snd_ce_b),
    .clip     (clip_b)
  );

  // Inputs change on negedge; outputs are sampled on negedge after a posedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance at least one cycle, then until snd_ce_a is seen (bounded).
  task automatic wait_pulse(input string nm, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!snd_ce_a && n < 20);
    if (!snd_ce_a) begin
      checks++;
      errors++;
      $display("FAIL %s: no snd_ce within %0d cycles", nm, n);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int d0, d1;
    int g0, g1;
    int k0, k1;
    int frames;    // check taken at this snd_ce pulse after release
    int exp_snd;
    int exp_clip;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  // Reset, then strobe both channels in the first cycle after release (slot 0),
  // follow snd_ce for v.frames pulses checking the 3-clock cadence, then check.
  task automatic run_vec(input vec_t v, input int idx);
    int cnt, lastp, p;
    rst_a      = 1'b1;
    din_a      = {16'(v.d1), 16'(v.d0)};
    gain_a     = {8'(v.g1), 8'(v.g0)};
    kshift_a   = {4'(v.k1), 4'(v.k0)};
    din_ce_a   = 2'b00;
    clip_clr_a = 1'b0;
    tick();
    tick();
    check($sformatf("vec%0d_rst_snd", idx), $signed(snd_a), 0);
    check($sformatf("vec%0d_rst_ce", idx), snd_ce_a, 0);
    check($sformatf("vec%0d_rst_clip", idx), clip_a, 0);
    rst_a    = 1'b0;
    din_ce_a = 2'b11;
    tick();
    din_ce_a = 2'b00;
    cnt = 1; lastp = 0; p = 0;
    while (p < v.frames && cnt < 60) begin
      if (snd_ce_a) begin
        p++;
        check($sformatf("vec%0d_ce_period", idx), cnt - lastp, 3);
        lastp = cnt;
      end
      if (p < v.frames) begin
        tick();
        cnt++;
      end
    end
    if (p < v.frames) begin
      checks++;
      errors++;
      $display("FAIL vec%0d_timeout: saw %0d pulses, needed %0d", idx, p, v.frames);
    end
    check($sformatf("vec%0d_snd", idx), $signed(snd_a), v.exp_snd);
    check($sformatf("vec%0d_clip", idx), clip_a, v.exp_clip);
  endtask

  // ---------------- reference model for instance B ----------------
  longint hold_m [CHB];
  longint f_m    [CHB];
  longint acc_m;
  int     ph_m;
  longint exp_snd;
  bit     exp_ce;
  bit     exp_clip;

  // Effect of one clock edge given the inputs currently applied.
  task automatic model_step();
    longint x, fn, g, v;
    int     kk;
    bit     sat;
    if (rst_b) begin
      for (int i = 0; i < CHB; i++) begin
        hold_m[i] = 0;
        f_m[i]    = 0;
      end
      acc_m = 0; ph_m = 0; exp_snd = 0; exp_ce = 0; exp_clip = 0;
    end else begin
      sat    = 0;
      exp_ce = 0;
      if (ph_m < CHB) begin
        kk = int'(kshift_b[ph_m*4 +: 4]);
        if (kk > 8) kk = 8;
        x  = hold_m[ph_m] * 256;
        fn = (kk == 0) ? x : f_m[ph_m] + ((x - f_m[ph_m]) >>> kk);
        g  = longint'(gain_b[ph_m*8 +: 8]);
        acc_m = acc_m + (fn >>> 8) * g;
        f_m[ph_m] = fn;
      end else begin
        v = acc_m >>> 4;
        if (v > 32767)  begin v = 32767;  sat = 1; end
        if (v < -32768) begin v = -32768; sat = 1; end
        exp_snd = v;
        exp_ce  = 1;
        acc_m   = 0;
      end
      if (sat) exp_clip = 1;
      else if (clip_clr_b) exp_clip = 0;
      ph_m = (ph_m == CHB) ? 0 : ph_m + 1;
      for (int i = 0; i < CHB; i++)
        if (din_ce_b[i]) hold_m[i] = longint'($signed(din_b[i*16 +: 16]));
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1000, -200, 16, 16, 0, 0, 1, -200, 0};
    vecs[1]  = '{1000, -200, 16, 16, 0, 0, 2, 800, 0};
    vecs[2]  = '{1000, -200, 16, 16, 0, 0, 4, 800, 0};
    vecs[3]  = '{30000, 30000, 16, 16, 0, 0, 2, 32767, 1};
    vecs[4]  = '{-30000, -30000, 16, 16, 0, 0, 2, -32768, 1};
    vecs[5]  = '{-1000, 0, 8, 16, 0, 0, 2, -500, 0};
    vecs[6]  = '{20000, 0, 32, 16, 0, 0, 2, 32767, 1};
    vecs[7]  = '{1024, 0, 16, 0, 1, 0, 2, 512, 0};
    vecs[8]  = '{1024, 0, 16, 0, 1, 0, 3, 768, 0};
    vecs[9]  = '{1024, 0, 16, 0, 1, 0, 5, 960, 0};
    vecs[10] = '{1024, 0, 16, 0, 0, 0, 2, 1024, 0};
    vecs[11] = '{1024, 0, 16, 0, 9, 0, 3, 7, 0};
    vecs[12] = '{1024, 0, 16, 0, 15, 0, 2, 4, 0};
    vecs[13] = '{-1001, 0, 16, 0, 1, 0, 2, -501, 0};
    vecs[14] = '{32767, 0, 16, 16, 0, 0, 2, 32767, 0};
    vecs[15] = '{-32768, 0, 16, 16, 0, 0, 2, -32768, 0};
    vecs[16] = '{0, 1024, 0, 16, 0, 1, 1, 512, 0};

    rst_a = 1'b1; din_a = '0; din_ce_a = '0; gain_a = '0; kshift_a = '0; clip_clr_a = 1'b0;
    rst_b = 1'b1; din_b = '0; din_ce_b = '0; gain_b = '0; kshift_b = '0; clip_clr_b = 1'b0;
    tick();
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // clip_clr away from OUT clears; coincident with a saturating OUT, set wins.
    run_vec(vecs[3], 100);
    clip_clr_a = 1'b1;
    tick();
    clip_clr_a = 1'b0;
    check("clr_mid_frame", clip_a, 0);
    tick();
    clip_clr_a = 1'b1;
    tick();
    clip_clr_a = 1'b0;
    check("clr_coinc_ce", snd_ce_a, 1);
    check("clr_coinc_clip", clip_a, 1);
    // Zero both inputs on the ch0 slot: ch0 still contributes its old value once.
    din_a = '0; din_ce_a = 2'b11; clip_clr_a = 1'b1;
    tick();
    din_ce_a = 2'b00; clip_clr_a = 1'b0;
    check("clr_quiet_clip", clip_a, 0);
    wait_pulse("zero_frame1", n);
    check("zero_frame1_gap", n, 2);
    check("zero_frame1_snd", $signed(snd_a), 30000);
    wait_pulse("zero_frame2", n);
    check("zero_frame2_gap", n, 3);
    check("zero_frame2_snd", $signed(snd_a), 0);
    check("zero_frame2_clip", clip_a, 0);

    // Reset in slot 1 with a partial accumulation and nonzero filter state.
    run_vec(vecs[9], 101);
    tick();
    rst_a = 1'b1;
    tick();
    check("midrst_snd", $signed(snd_a), 0);
    check("midrst_ce", snd_ce_a, 0);
    check("midrst_clip", clip_a, 0);
    rst_a = 1'b0;
    wait_pulse("midrst_first", n);
    check("midrst_first_gap", n, 3);
    check("midrst_first_snd", $signed(snd_a), 0);
    wait_pulse("midrst_second", n);
    check("midrst_second_snd", $signed(snd_a), 0);

    // Randomized traffic on the CH=5 instance, compared every cycle.
    for (int i = 0; i < CHB; i++) begin
      gain_b[i*8 +: 8]   = 8'($urandom_range(0, 32));
      kshift_b[i*4 +: 4] = 4'($urandom_range(0, 15));
    end
    for (int c = 0; c < 4000; c++) begin
      rst_b = (c < 2) || (c == 1503) || ($urandom_range(0, 599) == 0);
      for (int i = 0; i < CHB; i++) begin
        din_b[i*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                       : 16'($urandom_range(0, 4095) - 2048);
        din_ce_b[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 39) == 0) gain_b[i*8 +: 8] = 8'($urandom_range(0, 32));
        if ($urandom_range(0, 39) == 0) kshift_b[i*4 +: 4] = 4'($urandom_range(0, 15));
      end
      clip_clr_b = ($urandom_range(0, 15) == 0);
      model_step();
      tick();
      checks++;
      if (longint'($signed(snd_b)) != exp_snd || snd_ce_b != exp_ce || clip_b != exp_clip) begin
        errors++;
        $display("FAIL rand_out cycle %0d: got snd=%0d ce=%0d clip=%0d expected snd=%0d ce=%0d clip=%0d",
                 c, $signed(snd_b), snd_ce_b, clip_b, exp_snd, exp_ce, exp_clip);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
